// File: rtl/lookup_engine.sv
// Three-stage masked match-action lookup: capture key/PHV, compare against the
// priority-ordered table, then encode the winner and read its action.
module lookup_engine #(
    parameter int KEY_LEN  = 896,
    parameter int MASK_LEN = 896,
    parameter int PHV_LEN  = 1579,
    parameter int ACT_LEN  = 256,
    parameter int DEPTH    = 16,
    parameter int STAGE    = 0
) (
    input  logic                     axis_clk,
    input  logic                     areset,
    input  logic                     key_valid,
    input  logic [KEY_LEN-1:0]       extract_key,
    input  logic                     key_mask_valid,
    input  logic [MASK_LEN-1:0]      key_mask,
    input  logic                     cond_flag,
    input  logic [PHV_LEN-1:0]       phv_in,
    input  logic                     cfg_wr_en,
    input  logic [$clog2(DEPTH)-1:0] cfg_wr_addr,
    input  logic                     cfg_entry_valid,
    input  logic [KEY_LEN-1:0]       cfg_key,
    input  logic [MASK_LEN-1:0]      cfg_mask,
    input  logic [ACT_LEN-1:0]       cfg_action,
    output logic                     action_valid,
    output logic [ACT_LEN-1:0]       action,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] hit_index,
    output logic [PHV_LEN-1:0]       phv_out,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);
    localparam int IDX_W = $clog2(DEPTH);

    generate
        if (MASK_LEN != KEY_LEN || DEPTH < 2 || DEPTH > 64 ||
            (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0) begin : g_bad_params
            $error("lookup_engine: illegal parameterisation");
        end
    endgenerate

    logic [DEPTH-1:0]    tbl_valid;
    logic [KEY_LEN-1:0]  tbl_key    [DEPTH];
    logic [MASK_LEN-1:0] tbl_mask   [DEPTH];
    logic [ACT_LEN-1:0]  tbl_action [DEPTH];

    logic                s1_valid;
    logic [KEY_LEN-1:0]  s1_key;
    logic                s1_kmv;
    logic [MASK_LEN-1:0] s1_kmask;
    logic                s1_cond;
    logic [PHV_LEN-1:0]  s1_phv;

    logic                s2_valid;
    logic [DEPTH-1:0]    s2_match;
    logic [PHV_LEN-1:0]  s2_phv;

    logic [DEPTH-1:0]    match_vec;
    logic                enc_found;
    logic [IDX_W-1:0]    enc_idx;

    // All four fields of an entry change together so a lookup never sees a torn entry.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            tbl_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_key[i]    <= '0;
                tbl_mask[i]   <= '0;
                tbl_action[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            tbl_valid[cfg_wr_addr]  <= cfg_entry_valid;
            tbl_key[cfg_wr_addr]    <= cfg_key;
            tbl_mask[cfg_wr_addr]   <= cfg_mask;
            tbl_action[cfg_wr_addr] <= cfg_action;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s1_key   <= '0;
            s1_kmv   <= 1'b0;
            s1_kmask <= '0;
            s1_cond  <= 1'b0;
            s1_phv   <= '0;
        end else begin
            s1_valid <= key_valid;
            if (key_valid) begin
                s1_key   <= extract_key;
                s1_kmv   <= key_mask_valid;
                s1_kmask <= key_mask;
                s1_cond  <= cond_flag;
                s1_phv   <= phv_in;
            end
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [MASK_LEN-1:0] eff;
            eff = s1_kmv ? (tbl_mask[i] & s1_kmask) : tbl_mask[i];
            match_vec[i] = tbl_valid[i] && (((s1_key ^ tbl_key[i]) & eff) == '0);
        end
    end

    // A suppressed lookup (cond_flag low) is turned into a miss by clearing the vector.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            s2_valid <= 1'b0;
            s2_match <= '0;
            s2_phv   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_match <= s1_cond ? match_vec : '0;
                s2_phv   <= s1_phv;
            end
        end
    end

    always_comb begin
        enc_found = 1'b0;
        enc_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s2_match[i]) begin
                enc_found = 1'b1;
                enc_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            action_valid <= 1'b0;
            action       <= '0;
            hit          <= 1'b0;
            hit_index    <= '0;
            phv_out      <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            action_valid <= s2_valid;
            if (s2_valid) begin
                hit       <= enc_found;
                hit_index <= enc_found ? enc_idx : '0;
                action    <= enc_found ? tbl_action[enc_idx] : '0;
                phv_out   <= s2_phv;
                if (enc_found) begin
                    if (hit_count != 32'hFFFF_FFFF)
                        hit_count <= hit_count + 32'd1;
                end else if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lookup_engine.sv
// Self-checking bench for lookup_engine: directed table scenarios followed by
// randomized traffic against a cycle-indexed reference model of the table.
module tb_lookup_engine;
    localparam int KEY_LEN  = 896;
    localparam int MASK_LEN = 896;
    localparam int PHV_LEN  = 1579;
    localparam int ACT_LEN  = 256;
    localparam int DEPTH    = 16;
    localparam int IW       = 4;
    localparam int WIDE     = 1664;

    logic                axis_clk = 1'b0;
    logic                areset, key_valid, key_mask_valid, cond_flag;
    logic [KEY_LEN-1:0]  extract_key, cfg_key;
    logic [MASK_LEN-1:0] key_mask, cfg_mask;
    logic [PHV_LEN-1:0]  phv_in, phv_out;
    logic                cfg_wr_en, cfg_entry_valid;
    logic [IW-1:0]       cfg_wr_addr, hit_index;
    logic [ACT_LEN-1:0]  cfg_action, action;
    logic                action_valid, hit;
    logic [31:0]         hit_count, miss_count;

    lookup_engine dut (
        .axis_clk(axis_clk), .areset(areset), .key_valid(key_valid),
        .extract_key(extract_key), .key_mask_valid(key_mask_valid), .key_mask(key_mask),
        .cond_flag(cond_flag), .phv_in(phv_in), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_addr(cfg_wr_addr), .cfg_entry_valid(cfg_entry_valid), .cfg_key(cfg_key),
        .cfg_mask(cfg_mask), .cfg_action(cfg_action), .action_valid(action_valid),
        .action(action), .hit(hit), .hit_index(hit_index), .phv_out(phv_out),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [KEY_LEN-1:0]  key;
        logic                kmv;
        logic [MASK_LEN-1:0] kmask;
        logic                cond;
        logic [PHV_LEN-1:0]  phv;
        int                  issue;
        logic                hit;
        logic [IW-1:0]       idx;
        logic [ACT_LEN-1:0]  act;
    } req_t;

    req_t pend[$];

    logic                m_valid [DEPTH];
    logic [KEY_LEN-1:0]  m_key   [DEPTH];
    logic [MASK_LEN-1:0] m_mask  [DEPTH];
    logic [ACT_LEN-1:0]  m_act   [DEPTH];

    logic                exp_av, exp_hit;
    logic [IW-1:0]       exp_idx;
    logic [ACT_LEN-1:0]  exp_act;
    logic [PHV_LEN-1:0]  exp_phv;
    logic [31:0]         exp_hits, exp_misses;

    logic                n_kv, n_kmv, n_cond, n_wr, n_ev, n_rst;
    logic [KEY_LEN-1:0]  n_key, n_ck;
    logic [MASK_LEN-1:0] n_kmask, n_cm;
    logic [PHV_LEN-1:0]  n_phv;
    logic [IW-1:0]       n_addr;
    logic [ACT_LEN-1:0]  n_ca;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [KEY_LEN-1:0] hi_key;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkWide(input string tag, input logic [WIDE-1:0] got,
                             input logic [WIDE-1:0] exp, input int nbits);
        for (int k = 0; k < (nbits + 63) / 64; k++)
            checkOutput($sformatf("%s[%0d]", tag, k), got[k*64 +: 64], exp[k*64 +: 64]);
    endtask

    function automatic logic [WIDE-1:0] rndWide();
        logic [WIDE-1:0] r;
        for (int i = 0; i < WIDE / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void clearNext();
        n_kv = 0; n_kmv = 0; n_cond = 0; n_wr = 0; n_ev = 0; n_rst = 0;
        n_key = '0; n_ck = '0; n_kmask = '0; n_cm = '0; n_phv = '0; n_addr = '0; n_ca = '0;
    endfunction

    // Compare uses the table as it stands one cycle after issue, the action read
    // uses it two cycles after issue; the result is visible three cycles after issue.
    task automatic evaluate();
        foreach (pend[j]) begin
            if (pend[j].issue == cyc - 1) begin
                pend[j].hit = 1'b0;
                pend[j].idx = '0;
                if (pend[j].cond) begin
                    for (int i = DEPTH - 1; i >= 0; i--) begin
                        logic [MASK_LEN-1:0] em;
                        em = pend[j].kmv ? (m_mask[i] & pend[j].kmask) : m_mask[i];
                        if (m_valid[i] && ((pend[j].key ^ m_key[i]) & em) == '0) begin
                            pend[j].hit = 1'b1;
                            pend[j].idx = IW'(i);
                        end
                    end
                end
            end
            if (pend[j].issue == cyc - 2)
                pend[j].act = pend[j].hit ? m_act[pend[j].idx] : '0;
        end
        exp_av = 1'b0;
        if (pend.size() > 0 && pend[0].issue == cyc - 3) begin
            req_t r;
            r = pend.pop_front();
            exp_av  = 1'b1;
            exp_hit = r.hit;
            exp_idx = r.idx;
            exp_act = r.act;
            exp_phv = r.phv;
            if (r.hit) exp_hits++;
            else exp_misses++;
        end
        checkOutput("action_valid", 64'(action_valid), 64'(exp_av));
        checkOutput("hit", 64'(hit), 64'(exp_hit));
        checkOutput("hit_index", 64'(hit_index), 64'(exp_idx));
        checkOutput("hit_count", 64'(hit_count), 64'(exp_hits));
        checkOutput("miss_count", 64'(miss_count), 64'(exp_misses));
        checkWide("action", WIDE'(action), WIDE'(exp_act), ACT_LEN);
        checkWide("phv_out", WIDE'(phv_out), WIDE'(exp_phv), PHV_LEN);
    endtask

    task automatic applyStimulus();
        req_t r;
        areset = n_rst; key_valid = n_kv; extract_key = n_key; key_mask_valid = n_kmv;
        key_mask = n_kmask; cond_flag = n_cond; phv_in = n_phv; cfg_wr_en = n_wr;
        cfg_wr_addr = n_addr; cfg_entry_valid = n_ev; cfg_key = n_ck; cfg_mask = n_cm;
        cfg_action = n_ca;
        if (n_kv && !n_rst) begin
            r.key = n_key; r.kmv = n_kmv; r.kmask = n_kmask; r.cond = n_cond;
            r.phv = n_phv; r.issue = cyc; r.hit = 1'b0; r.idx = '0; r.act = '0;
            pend.push_back(r);
        end
        @(posedge axis_clk);
        #1;
        if (n_rst) begin
            pend.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0; m_key[i] = '0; m_mask[i] = '0; m_act[i] = '0;
            end
            exp_hit = 0; exp_idx = '0; exp_act = '0; exp_phv = '0;
            exp_hits = 0; exp_misses = 0;
        end else if (n_wr) begin
            m_valid[n_addr] = n_ev; m_key[n_addr] = n_ck;
            m_mask[n_addr] = n_cm; m_act[n_addr] = n_ca;
        end
        cyc++;
        evaluate();
        clearNext();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic doReset();
        n_rst = 1; n_kv = 1; n_cond = 1; n_key = '0;
        n_wr = 1; n_ev = 1; n_addr = 4'd3; n_cm = '0;
        applyStimulus();
    endtask

    task automatic sendKey(input logic [KEY_LEN-1:0] k, input logic kmv,
                           input logic [MASK_LEN-1:0] km, input logic cond);
        n_kv = 1; n_key = k; n_kmv = kmv; n_kmask = km; n_cond = cond;
        n_phv = rndWide()[PHV_LEN-1:0];
        applyStimulus();
    endtask

    task automatic writeEntry(input logic [IW-1:0] a, input logic v, input logic [KEY_LEN-1:0] k,
                              input logic [MASK_LEN-1:0] m, input logic [ACT_LEN-1:0] act);
        n_wr = 1; n_addr = a; n_ev = v; n_ck = k; n_cm = m; n_ca = act;
        applyStimulus();
    endtask

    function automatic logic [KEY_LEN-1:0] k8(input logic [7:0] v);
        return KEY_LEN'(v);
    endfunction

    initial begin
        exp_hit = 0; exp_idx = '0; exp_act = '0; exp_phv = '0; exp_hits = 0; exp_misses = 0;
        clearNext();
        doReset();

        sendKey(KEY_LEN'(16'h1234), 0, '0, 1);
        idle(2);
        checkOutput("dir_empty_miss_count", 64'(miss_count), 64'd1);
        checkOutput("dir_empty_action", action[63:0], 64'd0);

        writeEntry(5, 1, k8(8'hAB), MASK_LEN'(8'hFF), ACT_LEN'(8'h55));
        sendKey(KEY_LEN'(16'h12AB), 0, '0, 1);
        idle(2);
        checkOutput("dir_e5_hit_index", 64'(hit_index), 64'd5);
        checkOutput("dir_e5_action", action[63:0], 64'h55);
        checkOutput("dir_e5_hit_count", 64'(hit_count), 64'd1);

        writeEntry(2, 1, k8(8'h0B), MASK_LEN'(8'h0F), ACT_LEN'(8'h22));
        sendKey(k8(8'hAB), 0, '0, 1);
        idle(2);
        checkOutput("dir_prio_hit_index", 64'(hit_index), 64'd2);
        checkOutput("dir_prio_action", action[63:0], 64'h22);
        writeEntry(2, 0, k8(8'h0B), MASK_LEN'(8'h0F), ACT_LEN'(8'h22));
        sendKey(k8(8'hAB), 0, '0, 1);
        idle(2);
        checkOutput("dir_inval_hit_index", 64'(hit_index), 64'd5);

        sendKey(k8(8'hAB), 0, '0, 0);
        idle(2);
        checkOutput("dir_cond_hit", 64'(hit), 64'd0);
        sendKey(k8(8'h3C), 1, '0, 1);
        idle(2);
        checkOutput("dir_zero_mask_lowest", 64'(hit_index), 64'd5);
        writeEntry(0, 1, k8(8'h77), MASK_LEN'(8'hFF), ACT_LEN'(8'h99));
        sendKey(k8(8'h3C), 1, '0, 1);
        idle(2);
        checkOutput("dir_zero_mask_e0", 64'(hit_index), 64'd0);
        checkOutput("dir_zero_mask_e0_action", action[63:0], 64'h99);

        // Back-to-back keys with entry 5 rewritten in the second cycle.
        sendKey(k8(8'hAB), 0, '0, 1);
        n_wr = 1; n_addr = 5; n_ev = 1; n_ck = k8(8'hCD); n_cm = MASK_LEN'(8'hFF);
        n_ca = ACT_LEN'(8'h66);
        sendKey(k8(8'hAB), 0, '0, 1);
        sendKey(k8(8'hAB), 0, '0, 1);
        checkOutput("dir_b2b0_hit", 64'(hit), 64'd1);
        checkOutput("dir_b2b0_action", action[63:0], 64'h66);
        sendKey(k8(8'hCD), 0, '0, 1);
        checkOutput("dir_b2b1_hit", 64'(hit), 64'd0);
        idle(1);
        checkOutput("dir_b2b2_hit", 64'(hit), 64'd0);
        idle(1);
        checkOutput("dir_b2b3_hit_index", 64'(hit_index), 64'd5);
        checkOutput("dir_b2b3_valid", 64'(action_valid), 64'd1);

        sendKey(k8(8'hCD), 0, '0, 1);
        sendKey(k8(8'hCD), 0, '0, 1);
        doReset();
        idle(3);
        checkOutput("dir_rst_hit_count", 64'(hit_count), 64'd0);
        sendKey(k8(8'hCD), 0, '0, 1);
        idle(2);
        checkOutput("dir_rst_miss", 64'(hit), 64'd0);
        checkOutput("dir_rst_miss_count", 64'(miss_count), 64'd1);

        // Randomized traffic; entry keys share a random upper part so hits are common.
        hi_key = rndWide()[KEY_LEN-1:0];
        for (int c = 0; c < 400; c++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 25) begin
                logic [MASK_LEN-1:0] m;
                m = ($urandom_range(0, 3) == 0) ? rndWide()[MASK_LEN-1:0] : '1;
                m[7:0] = 8'($urandom);
                n_wr = 1; n_addr = IW'($urandom); n_ev = ($urandom_range(0, 4) != 0);
                n_ck = {hi_key[KEY_LEN-1:8], 8'($urandom)}; n_cm = m;
                n_ca = rndWide()[ACT_LEN-1:0];
            end
            if ($urandom_range(0, 9) < 7) begin
                n_kv = 1;
                n_key = {hi_key[KEY_LEN-1:8], 8'($urandom)};
                if ($urandom_range(0, 9) == 0) n_key[$urandom_range(8, KEY_LEN - 1)] ^= 1'b1;
                n_kmv = 1'($urandom);
                n_kmask = ($urandom_range(0, 3) == 0) ? rndWide()[MASK_LEN-1:0] : '1;
                n_kmask[7:0] = 8'($urandom);
                n_cond = ($urandom_range(0, 7) != 0);
                n_phv = rndWide()[PHV_LEN-1:0];
            end
            if ($urandom_range(0, 149) == 0) n_rst = 1;
            applyStimulus();
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lookup_engine.md
# lookup_engine

Masked match-action lookup stage that sits directly downstream of the key extractor in each pipeline stage. It consumes the extracted key, the key mask, the conditional flag and the PHV, and compares the masked key against a DEPTH-entry, priority-ordered, software-programmed table. It emits the matching entry's action word together with the PHV, aligned, to the action engine.

## Interface
- KEY_LEN, 896, key width (matches extractor key)
- MASK_LEN, 896, mask width; must equal KEY_LEN
- PHV_LEN, 1579, packet header vector width
- ACT_LEN, 256, action word width
- DEPTH, 16, table entries; power of two, 2..64
- STAGE, 0, stage index; informational only, no logic impact
- axis_clk  in  1  sole clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- key_valid  in  1  single-cycle strobe; key, mask, cond and PHV valid this cycle
- extract_key  in  KEY_LEN  lookup key
- key_mask_valid  in  1  key_mask qualifies this key
- key_mask  in  MASK_LEN  per-key compare mask, 1 = compare bit
- cond_flag  in  1  0 = skip lookup, force miss
- phv_in  in  PHV_LEN  PHV accompanying the key
- cfg_wr_en  in  1  table write strobe
- cfg_wr_addr  in  $clog2(DEPTH)  entry index
- cfg_entry_valid  in  1  valid bit written to entry
- cfg_key  in  KEY_LEN  entry key
- cfg_mask  in  MASK_LEN  entry mask, 1 = compare bit
- cfg_action  in  ACT_LEN  entry action
- action_valid  out  1  single-cycle result strobe
- action  out  ACT_LEN  hit entry's action; all-zero on miss (no-op)
- hit  out  1  1 = some entry matched
- hit_index  out  $clog2(DEPTH)  winning entry; 0 on miss
- phv_out  out  PHV_LEN  PHV aligned with action_valid
- hit_count  out  32  total hits since reset, saturating
- miss_count  out  32  total misses since reset, saturating

## Operation
- Table: per entry, a valid bit, key, mask and action. Written only via cfg port; a write updates all four fields of cfg_wr_addr atomically at the edge ending the cfg_wr_en cycle.
- Effective mask for entry i: cfg_mask[i] & key_mask when key_mask_valid=1, else cfg_mask[i].
- Entry i matches iff valid[i]=1 and ((extract_key ^ key[i]) & effmask_i) == 0. An all-zero effective mask matches any key.
- Priority: the lowest matching index wins.
- cond_flag=0: result is a miss regardless of the table; miss_count increments.
- Pipeline, three registered stages, no backpressure, accepts key_valid every cycle:
  - S1: capture key, mask, key_mask_valid, cond_flag and PHV.
  - S2: compute the DEPTH-bit match vector against the table and register it; cond_flag=0 zeroes the vector.
  - S3: priority-encode, read the action from the table, drive the outputs and update the counters.
- Counters: exactly one of hit_count or miss_count increments per action_valid; each holds at 0xFFFF_FFFF.
- Outputs hold their last values between strobes; only action_valid deasserts.

## Timing
- key_valid sampled high in cycle T -> action_valid=1 in cycle T+3, exactly one cycle; latency is fixed at 3.
- Back-to-back keys in T and T+1 -> results in T+3 and T+4, in order, none dropped.
- Table consistency: the compare for a key sampled in T uses table state in cycle T+1; its action read uses table state in cycle T+2. A write in cycle W is visible to compares in cycles ≥ W+1.
- cfg_wr_en concurrent with lookups: the write always commits; no stall.
- Reset values: action_valid=0, action=0, hit=0, hit_index=0, phv_out=0, hit_count=0, miss_count=0, all pipeline valids=0, all entries invalid with key, mask and action zero.
- areset asserted mid-operation: in-flight lookups are discarded with no action_valid, and the table is cleared. Inputs present during the areset cycle are ignored.
- key_mask_valid and cond_flag are meaningful only when key_valid=1.

## Test plan
- After reset, with an empty table, send key 0x1234 (low bits, rest 0) with cond_flag=1 -> action_valid at T+3, hit=0, action=0, hit_index=0, miss_count=1.
- Write entry 5 with key=0xAB, mask=0xFF, action=0x55; send key 0x12AB -> hit=1, hit_index=5, action=0x55, phv_out equals phv_in, hit_count=1.
- Write entry 2 (mask 0x0F, key 0x0B, action 0x22) and entry 5 as above; send key 0xAB -> hit_index=2, action=0x22; then invalidate entry 2 and resend -> hit_index=5.
- Same table as the previous step; send key 0xAB with cond_flag=0 -> hit=0, action=0. Send it with key_mask_valid=1, key_mask=0 -> hit_index=0 with entry 0 valid, otherwise the lowest valid entry.
- Four back-to-back keys, with a cfg write to the matching entry in cycle T0+1 -> results in four consecutive cycles; the key from T0 sees the old table in S2, keys from T0+1 onward see the new table.
- Assert areset for 1 cycle with two keys in flight -> no action_valid, counters 0; a subsequent key on the cleared table -> miss.
